pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB) and PC.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 14 +
 rtl/pipeline_hazard_ctrl_if.sv | 39 +++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: sequencer states
// and the hard-wired zero register index.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALT   = 2'd2,
        RESUME = 2'd3
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side hazard bus: ID/EX instruction info and resume request into
// the controller, per-stage enables and flushes back to the pipeline.
interface pipeline_hazard_ctrl_if;

    logic [4:0] ID_rs;
    logic [4:0] ID_rt;
    logic       ID_use_rs;
    logic       ID_use_rt;
    logic       ID_halt;
    logic       EX_ramtoreg;
    logic [4:0] EX_wreg;
    logic       EX_branch_taken;
    logic       go;

    logic       PC_en;
    logic       IF_ID_en;
    logic       IF_ID_flush;
    logic       ID_EX_en;
    logic       ID_EX_flush;
    logic       EX_MEM_en;
    logic       MEM_WB_en;

    // Pipeline datapath side
    modport master (
        output ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_halt,
               EX_ramtoreg, EX_wreg, EX_branch_taken, go,
        input  PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
               EX_MEM_en, MEM_WB_en
    );

    // Hazard controller side
    modport slave (
        input  ID_rs, ID_rt, ID_use_rs, ID_use_rt, ID_halt,
               EX_ramtoreg, EX_wreg, EX_branch_taken, go,
        output PC_en, IF_ID_en, IF_ID_flush, ID_EX_en, ID_EX_flush,
               EX_MEM_en, MEM_WB_en
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection: the instruction in EX is a load whose
// destination (other than $zero) is read by the instruction in ID.
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [4:0] ID_rs,
    input  logic [4:0] ID_rt,
    input  logic       ID_use_rs,
    input  logic       ID_use_rt,
    input  logic       EX_ramtoreg,
    input  logic [4:0] EX_wreg,
    output logic       load_use
);

    // Pure compare, no state
    always_comb begin
        load_use = EX_ramtoreg && (EX_wreg != REG_ZERO) &&
                   ((ID_use_rs && (ID_rs == EX_wreg)) ||
                    (ID_use_rt && (ID_rt == EX_wreg)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer for PC and the IF_ID/ID_EX/EX_MEM/MEM_WB registers:
// load-use stalls, taken-branch flushes, syscall drain/halt/resume, and
// wrapping stall/flush statistics.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned DRAIN_CYC = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave hz,
    output logic                 halted,
    output logic [CNT_WIDTH-1:0] stall_cnt,
    output logic [CNT_WIDTH-1:0] flush_cnt
);

    localparam int unsigned DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN_CYC - 1);

    hz_state_t         state, state_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt;
    logic              load_use;
    logic              stall_inc;
    logic              flush_inc;

    hazard_detect u_hazard_detect (
        .ID_rs       (hz.ID_rs),
        .ID_rt       (hz.ID_rt),
        .ID_use_rs   (hz.ID_use_rs),
        .ID_use_rt   (hz.ID_use_rt),
        .EX_ramtoreg (hz.EX_ramtoreg),
        .EX_wreg     (hz.EX_wreg),
        .load_use    (load_use)
    );

    // Next state and same-cycle stage controls; reset forces RUN defaults
    always_comb begin
        state_nxt      = state;
        dcnt_nxt       = dcnt;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;
        hz.PC_en       = 1'b1;
        hz.IF_ID_en    = 1'b1;
        hz.IF_ID_flush = 1'b0;
        hz.ID_EX_en    = 1'b1;
        hz.ID_EX_flush = 1'b0;
        hz.EX_MEM_en   = 1'b1;
        hz.MEM_WB_en   = 1'b1;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (hz.EX_branch_taken) begin
                        hz.IF_ID_flush = 1'b1;
                        hz.ID_EX_flush = 1'b1;
                        flush_inc      = 1'b1;
                    end else if (load_use) begin
                        hz.PC_en       = 1'b0;
                        hz.IF_ID_en    = 1'b0;
                        hz.ID_EX_flush = 1'b1;
                        stall_inc      = 1'b1;
                    end else if (hz.ID_halt) begin
                        hz.PC_en       = 1'b0;
                        hz.IF_ID_en    = 1'b0;
                        hz.ID_EX_flush = 1'b1;
                        state_nxt      = DRAIN;
                        dcnt_nxt       = '0;
                    end
                end
                DRAIN: begin
                    hz.PC_en       = 1'b0;
                    hz.IF_ID_en    = 1'b0;
                    hz.ID_EX_flush = 1'b1;
                    dcnt_nxt       = dcnt + 1'b1;
                    if (dcnt == DCNT_LAST) begin
                        state_nxt = HALT;
                    end
                end
                HALT: begin
                    hz.PC_en     = 1'b0;
                    hz.IF_ID_en  = 1'b0;
                    hz.ID_EX_en  = 1'b0;
                    hz.EX_MEM_en = 1'b0;
                    hz.MEM_WB_en = 1'b0;
                    if (hz.go) begin
                        state_nxt = RESUME;
                    end
                end
                RESUME: begin
                    hz.ID_EX_flush = 1'b1;
                    state_nxt      = RUN;
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    // State, drain counter, halted flag and statistics registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            dcnt      <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            dcnt      <= dcnt_nxt;
            halted    <= (state_nxt == HALT);
            stall_cnt <= stall_cnt + CNT_WIDTH'(stall_inc);
            flush_cnt <= flush_cnt + CNT_WIDTH'(flush_inc);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed
// by randomized traffic, compared against a behavioural model of the
// sequencer rules. Counters run at 4 bits so wrap-around is reachable.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CW = 4;
    localparam int unsigned DRAIN_N = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          halted;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    int errors = 0;
    int checks = 0;

    // Behavioural model: phase flags plus drain progress and event totals
    bit m_halted;
    bit m_drain;
    bit m_resume;
    int m_drain_done;
    int m_stall;
    int m_flush;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(
        .CNT_WIDTH (CW),
        .DRAIN_CYC (DRAIN_N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (bus.slave),
        .halted    (halted),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic bit model_load_use();
        if (!bus.EX_ramtoreg || bus.EX_wreg == 5'd0) return 1'b0;
        return (bus.ID_use_rs && bus.ID_rs == bus.EX_wreg) ||
               (bus.ID_use_rt && bus.ID_rt == bus.EX_wreg);
    endfunction

    task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                          input bit hlt, input bit ld, input int wreg,
                          input bit br, input bit go_v);
        bus.ID_rs           = 5'(rs);
        bus.ID_rt           = 5'(rt);
        bus.ID_use_rs       = urs;
        bus.ID_use_rt       = urt;
        bus.ID_halt         = hlt;
        bus.EX_ramtoreg     = ld;
        bus.EX_wreg         = 5'(wreg);
        bus.EX_branch_taken = br;
        bus.go              = go_v;
    endtask

    // Check outputs mid-cycle, then advance the model at the clock edge
    task automatic cycle();
        bit pc, ifid, ifidf, idex, idexf, exmem, memwb;
        logic [6:0] obs, exp;
        @(negedge clk);
        pc = 1; ifid = 1; ifidf = 0; idex = 1; idexf = 0; exmem = 1; memwb = 1;
        if (rst) begin
            // RUN defaults, no stall
        end else if (m_halted) begin
            pc = 0; ifid = 0; idex = 0; exmem = 0; memwb = 0;
        end else if (m_drain) begin
            pc = 0; ifid = 0; idexf = 1;
        end else if (m_resume) begin
            idexf = 1;
        end else if (bus.EX_branch_taken) begin
            ifidf = 1; idexf = 1;
        end else if (model_load_use() || bus.ID_halt) begin
            pc = 0; ifid = 0; idexf = 1;
        end
        exp = {pc, ifid, ifidf, idex, idexf, exmem, memwb};
        obs = {bus.PC_en, bus.IF_ID_en, bus.IF_ID_flush, bus.ID_EX_en,
               bus.ID_EX_flush, bus.EX_MEM_en, bus.MEM_WB_en};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL ctrl t=%0t observed=%b expected=%b", $time, obs, exp);
        end
        checks++;
        assert (halted === m_halted) else begin
            errors++;
            $error("FAIL halted t=%0t observed=%b expected=%b", $time, halted, m_halted);
        end
        checks++;
        assert (stall_cnt === CW'(m_stall)) else begin
            errors++;
            $error("FAIL stall_cnt t=%0t observed=%0d expected=%0d", $time, stall_cnt, CW'(m_stall));
        end
        checks++;
        assert (flush_cnt === CW'(m_flush)) else begin
            errors++;
            $error("FAIL flush_cnt t=%0t observed=%0d expected=%0d", $time, flush_cnt, CW'(m_flush));
        end

        @(posedge clk);
        if (rst) begin
            m_halted = 0; m_drain = 0; m_resume = 0; m_drain_done = 0;
            m_stall = 0; m_flush = 0;
        end else if (m_halted) begin
            if (bus.go) begin
                m_halted = 0;
                m_resume = 1;
            end
        end else if (m_drain) begin
            m_drain_done++;
            if (m_drain_done == DRAIN_N) begin
                m_drain = 0;
                m_halted = 1;
            end
        end else if (m_resume) begin
            m_resume = 0;
        end else if (bus.EX_branch_taken) begin
            m_flush++;
        end else if (model_load_use()) begin
            m_stall++;
        end else if (bus.ID_halt) begin
            m_drain = 1;
            m_drain_done = 0;
        end
        #1;
    endtask

    initial begin
        int waited;
        m_halted = 0; m_drain = 0; m_resume = 0; m_drain_done = 0;
        m_stall = 0; m_flush = 0;
        rst = 1'b1;
        // Reset cycle with a live load-use on the inputs: must not stall
        set_in(8, 0, 1, 0, 0, 1, 8, 0, 0);
        #1;
        cycle();
        rst = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Load-use on rs
        set_in(8, 3, 1, 0, 0, 1, 8, 0, 0);
        cycle();
        // Load-use on rt only
        set_in(2, 9, 0, 1, 0, 1, 9, 0, 0);
        cycle();
        // Matching register but not read
        set_in(8, 8, 0, 0, 0, 1, 8, 0, 0);
        cycle();
        // Destination $zero never stalls
        set_in(0, 3, 1, 0, 0, 1, 0, 0, 0);
        cycle();
        // Branch wins over load-use
        set_in(8, 3, 1, 0, 0, 1, 8, 1, 0);
        cycle();
        // Branch wins over halt
        set_in(0, 0, 0, 0, 1, 0, 0, 1, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        // Halt, drain (go ignored), halt, resume with ID_halt ignored
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        waited = 0;
        while (!halted && waited < 10) begin
            cycle();
            waited++;
        end
        checks++;
        assert (halted === 1'b1 && waited == DRAIN_N - 1) else begin
            errors++;
            $error("FAIL drain_len observed=%0d expected=%0d halted=%b", waited, DRAIN_N - 1, halted);
        end
        cycle();
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 1);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        cycle();

        // Reset while halted
        set_in(0, 0, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        checks++;
        assert (halted === 1'b0 && stall_cnt === '0 && flush_cnt === '0) else begin
            errors++;
            $error("FAIL post_rst observed halted=%b stall=%0d flush=%0d expected 0/0/0",
                   halted, stall_cnt, flush_cnt);
        end

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 3), $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), ($urandom_range(0, 4) == 0),
                   ($urandom_range(0, 3) == 0));
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end
        rst = 1'b0;

        // Counter wrap: 17 stalls in a 4-bit counter
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_in(5, 0, 1, 0, 0, 1, 5, 0, 0);
        for (int i = 0; i < 17; i++) cycle();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        checks++;
        assert (stall_cnt === 4'd1) else begin
            errors++;
            $error("FAIL wrap observed=%0d expected=1", stall_cnt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
